fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register. Owns the PC and drives the
//  instruction-memory read handshake. Delivers instruction_d/pcplus4_d to decode.
//  Consumes decode's redirect ({jmp,branch_taken} on pc_src_d, plus pc_branch_d).
//  Squashes the wrong-path fetch and holds under hazard-unit stall.
// PARAMETERS
//  INSTR_WIDTH  32           instruction / PC width
//  RESET_PC     32'h0000_0000 PC value loaded on reset
//  NOP_INSTR    32'h0000_0000 bubble word written into IF/ID (sll $0,$0,0)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  stall        in   1   hazard unit: freeze PC and IF/ID
//  pc_src_d     in   2   decode redirect: 00 seq, 01 branch, 10/11 jump (jump wins)
//  pc_branch_d  in   32  branch target from decode
//  imem_rdata   in   32  instruction word from instruction memory
//  imem_valid   in   1   imem_rdata valid for current imem_addr (same cycle or later)
//  imem_req     out  1   read request; 1 whenever reset is low
//  imem_addr    out  32  = pc_f; held stable while imem_req=1 and imem_valid=0
//  pc_f         out  32  current fetch PC
//  instruction_d out 32  IF/ID instruction
//  pcplus4_d    out  32  IF/ID PC+4 of that instruction
//  valid_d      out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async): pc_f=RESET_PC, instruction_d=NOP_INSTR, pcplus4_d=0, valid_d=0,
//   pending=0, state=FETCH, imem_req=0 while reset is high.
//  Targets: branch = pc_branch_d; jump = {pcplus4_d[31:28], instruction_d[25:0], 2'b00}.
//   Any loaded PC has bits [1:0] forced to 0. PC+4 wraps mod 2^32 (FFFF_FFFC -> 0).
//  FSM FETCH (normal), in priority order per cycle:
//   1 stall=1: PC, IF/ID, state held; pc_src_d ignored (hazard unit guarantees resample).
//   2 pc_src_d!=0, imem_valid=1: pc_f<=target; IF/ID<=bubble (word is wrong-path).
//   3 pc_src_d!=0, imem_valid=0: pending<=target; IF/ID<=bubble; PC held; ->DRAIN.
//   4 imem_valid=1: pc_f<=pc_f+4; IF/ID<={imem_rdata, pc_f+4, valid=1}.
//   5 imem_valid=0: PC held; IF/ID<=bubble (valid_d=0).
//  FSM DRAIN (outstanding wrong-path read; address must stay stable):
//   imem_addr stays old pc_f; pc_src_d ignored; IF/ID<=bubble unless stall (then held).
//   imem_valid=1: word discarded, pc_f<=pending, ->FETCH (completes even under stall).
//  Latency: imem_valid in cycle N -> instruction_d visible after edge N. Zero-wait memory
//   gives 1 instr/cycle. Taken branch/jump costs 1 bubble (+ wait cycles in DRAIN).
//  Bubble = {NOP_INSTR, pcplus4_d unchanged, valid_d=0}.
//  Reset mid-DRAIN or mid-wait: everything to reset values; late imem_valid is ignored.
// TESTING
//  T1 reset, imem_valid=1 always, words W0..W3 -> pc_f 0,4,8,C; instruction_d=W0..W3
//     one cycle behind, pcplus4_d=4,8,C,10, valid_d=1.
//  T2 pc_src_d=01, pc_branch_d=0x40, imem_valid=1 -> next pc_f=0x40, valid_d=0 for
//     one cycle; word from 0x40 in IF/ID the cycle after.
//  T3 instruction_d=0x0800_0010 (j), pcplus4_d=0x1000_0008, pc_src_d=10
//     -> pc_f=0x1000_0040. pc_src_d=11 also takes the jump.
//  T4 imem_valid low 3 cycles at pc_f=0x20 with pc_src_d=01 (target 0x80) in first
//     -> imem_addr stays 0x20 until valid, word dropped, then pc_f=0x80, no valid_d=1.
//  T5 stall=1 for 2 cycles with pc_src_d=01 -> pc_f and IF/ID frozen, no redirect.
//     Deassert -> sequential fetch resumes from held PC.
//  T6 pc_f=0xFFFF_FFFC -> next 0x0; reset asserted mid-DRAIN -> pc_f=RESET_PC
//     asynchronously, valid_d=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem read handshake and the IF/ID
// register. A redirect that arrives while a read is outstanding parks in DRAIN until it lands.
module fetch_stage #(
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [1:0]             pc_src_d,
    input  logic [INSTR_WIDTH-1:0] pc_branch_d,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic                   imem_req,
    output logic [INSTR_WIDTH-1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0] pc_f,
    output logic [INSTR_WIDTH-1:0] instruction_d,
    output logic [INSTR_WIDTH-1:0] pcplus4_d,
    output logic                   valid_d
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] pending;
    logic [INSTR_WIDTH-1:0] pcplus4_f;
    logic [INSTR_WIDTH-1:0] jump_target;
    logic [INSTR_WIDTH-1:0] redirect_target;
    logic                   redirect;

    assign pcplus4_f   = pc_f + INSTR_WIDTH'(4);
    assign jump_target = {pcplus4_d[INSTR_WIDTH-1:28], instruction_d[25:0], 2'b00};
    // Jump wins over branch whenever pc_src_d[1] is set; loaded PCs are word aligned.
    assign redirect_target = (pc_src_d[1] ? jump_target : pc_branch_d) & ~INSTR_WIDTH'(3);
    assign redirect    = |pc_src_d;

    assign imem_req  = ~reset;
    assign imem_addr = pc_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc_f          <= RESET_PC;
            pending       <= '0;
            instruction_d <= NOP_INSTR;
            pcplus4_d     <= '0;
            valid_d       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (redirect) begin
                            instruction_d <= NOP_INSTR;
                            valid_d       <= 1'b0;
                            if (imem_valid) begin
                                pc_f <= redirect_target;
                            end else begin
                                pending <= redirect_target;
                                state   <= DRAIN;
                            end
                        end else if (imem_valid) begin
                            pc_f          <= pcplus4_f;
                            instruction_d <= imem_rdata;
                            pcplus4_d     <= pcplus4_f;
                            valid_d       <= 1'b1;
                        end else begin
                            instruction_d <= NOP_INSTR;
                            valid_d       <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The wrong-path word is dropped; the read retires even under stall.
                    if (imem_valid) begin
                        pc_f  <= pending;
                        state <= FETCH;
                    end
                    if (!stall) begin
                        instruction_d <= NOP_INSTR;
                        valid_d       <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
